// File: rtl/hunterjfs_pkg.sv
// hunterjfs_pkg: shared opcode encoding for the accumulator ALU tile.
//   opcode_t - 3-bit opcode carried on uio_in[2:0]
package hunterjfs_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_XOR  = 3'd6,
        OP_ROL  = 3'd7
    } opcode_t;

endpackage

// File: rtl/hunterjfs_alu.sv
// hunterjfs_alu: combinational next-state for accumulator and C/V flags.
//   i_acc  current accumulator      i_b    operand B
//   i_op   opcode                   i_c/i_v current carry / overflow flags
//   o_acc  next accumulator         o_c/o_v next carry / overflow flags
module hunterjfs_alu
    import hunterjfs_pkg::*;
(
    input  logic [7:0] i_acc,
    input  logic [7:0] i_b,
    input  opcode_t    i_op,
    input  logic       i_c,
    input  logic       i_v,
    output logic [7:0] o_acc,
    output logic       o_c,
    output logic       o_v
);

    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic       w_add_v;
    logic       w_sub_v;

    // Bit 8 of the 9-bit results is carry-out for add and borrow for subtract.
    assign w_sum   = {1'b0, i_acc} + {1'b0, i_b};
    assign w_diff  = {1'b0, i_acc} - {1'b0, i_b};
    assign w_add_v = (i_acc[7] == i_b[7]) && (w_sum[7] != i_acc[7]);
    assign w_sub_v = (i_acc[7] != i_b[7]) && (w_diff[7] != i_acc[7]);

    always_comb begin
        o_acc = i_acc;
        o_c   = 1'b0;
        o_v   = 1'b0;
        case (i_op)
            OP_NOP:  begin o_c = i_c; o_v = i_v; end
            OP_LOAD: o_acc = i_b;
            OP_ADD:  begin o_acc = w_sum[7:0];  o_c = w_sum[8];  o_v = w_add_v; end
            OP_SUB:  begin o_acc = w_diff[7:0]; o_c = w_diff[8]; o_v = w_sub_v; end
            OP_AND:  o_acc = i_acc & i_b;
            OP_OR:   o_acc = i_acc | i_b;
            OP_XOR:  o_acc = i_acc ^ i_b;
            OP_ROL:  begin o_acc = {i_acc[6:0], i_acc[7]}; o_c = i_acc[7]; end
            default: begin o_c = i_c; o_v = i_v; end
        endcase
    end

endmodule

// File: rtl/tt_um_hunterjfs.sv
// tt_um_hunterjfs: Tiny Tapeout tile, 8-bit accumulator ALU with status flags.
//   ui_in    operand B              uio_in  [2:0] opcode, [3] exec strobe
//   uo_out   accumulator            uio_out [4] Z, [5] C, [6] N, [7] V
//   uio_oe   constant 8'hF0         ena     tile select, holds state when low
module tt_um_hunterjfs
    import hunterjfs_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [7:0] r_acc;
    logic       r_c;
    logic       r_v;
    logic [7:0] w_acc_nxt;
    logic       w_c_nxt;
    logic       w_v_nxt;
    logic       w_unused;

    assign w_unused = &{1'b0, uio_in[7:4]};

    hunterjfs_alu u_alu (
        .i_acc (r_acc),
        .i_b   (ui_in),
        .i_op  (opcode_t'(uio_in[2:0])),
        .i_c   (r_c),
        .i_v   (r_v),
        .o_acc (w_acc_nxt),
        .o_c   (w_c_nxt),
        .o_v   (w_v_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= 8'h00;
            r_c   <= 1'b0;
            r_v   <= 1'b0;
        end else if (ena && uio_in[3]) begin
            r_acc <= w_acc_nxt;
            r_c   <= w_c_nxt;
            r_v   <= w_v_nxt;
        end
    end

    // Z and N follow the registered accumulator directly.
    assign uo_out  = r_acc;
    assign uio_out = {r_v, r_acc[7], r_c, r_acc == 8'h00, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_hunterjfs.sv
// tb_tt_um_hunterjfs: table-driven scoreboard bench for the accumulator ALU tile.
module tb_tt_um_hunterjfs;
    import hunterjfs_pkg::*;

    typedef struct {
        string      name;
        logic       ena;
        logic       exec;
        logic [2:0] op;
        logic [7:0] b;
        logic [7:0] acc;
        logic [7:0] flg;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    tt_um_hunterjfs dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string name);
        logic [15:0] e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            chk({name, ".acc"}, uo_out, e[15:8]);
            chk({name, ".flags"}, uio_out, e[7:0]);
            chk({name, ".oe"}, uio_oe, 8'hF0);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        ena    = v.ena;
        uio_in = {4'b1010, v.exec, v.op};
        ui_in  = v.b;
        sb.push_back({v.acc, v.flg});
        @(posedge clk);
        #1;
        pop_chk(v.name);
    endtask

    initial begin
        tbl.push_back('{"load_f0",   1, 1, OP_LOAD, 8'hF0, 8'hF0, 8'h40});
        tbl.push_back('{"add_carry", 1, 1, OP_ADD,  8'h20, 8'h10, 8'h20});
        tbl.push_back('{"load_7f",   1, 1, OP_LOAD, 8'h7F, 8'h7F, 8'h00});
        tbl.push_back('{"add_ovf",   1, 1, OP_ADD,  8'h01, 8'h80, 8'hC0});
        tbl.push_back('{"sub_brw",   1, 1, OP_SUB,  8'h81, 8'hFF, 8'h60});
        tbl.push_back('{"load_aa",   1, 1, OP_LOAD, 8'hAA, 8'hAA, 8'h40});
        tbl.push_back('{"and_zero",  1, 1, OP_AND,  8'h55, 8'h00, 8'h10});
        tbl.push_back('{"or_0f",     1, 1, OP_OR,   8'h0F, 8'h0F, 8'h00});
        tbl.push_back('{"xor_ff",    1, 1, OP_XOR,  8'hFF, 8'hF0, 8'h40});
        tbl.push_back('{"load_81",   1, 1, OP_LOAD, 8'h81, 8'h81, 8'h40});
        tbl.push_back('{"rol_1",     1, 1, OP_ROL,  8'hFF, 8'h03, 8'h20});
        tbl.push_back('{"rol_2",     1, 1, OP_ROL,  8'h00, 8'h06, 8'h00});
        tbl.push_back('{"load_7f_b", 1, 1, OP_LOAD, 8'h7F, 8'h7F, 8'h00});
        tbl.push_back('{"add_ovf_b", 1, 1, OP_ADD,  8'h01, 8'h80, 8'hC0});
        tbl.push_back('{"no_exec",   1, 0, OP_ADD,  8'h11, 8'h80, 8'hC0});
        tbl.push_back('{"ena_low",   0, 1, OP_ADD,  8'h11, 8'h80, 8'hC0});
        tbl.push_back('{"nop",       1, 1, OP_NOP,  8'h11, 8'h80, 8'hC0});
        tbl.push_back('{"sub_ovf",   1, 1, OP_SUB,  8'h01, 8'h7F, 8'h80});
        tbl.push_back('{"add_ff",    1, 1, OP_ADD,  8'hFF, 8'h7E, 8'h20});
        tbl.push_back('{"sub_eq",    1, 1, OP_SUB,  8'h7E, 8'h00, 8'h10});

        #1 rst_n = 1'b0;
        #1;
        chk("rst_async.acc", uo_out, 8'h00);
        chk("rst_async.flags", uio_out, 8'h10);
        chk("rst_async.oe", uio_oe, 8'hF0);
        uio_in = {4'b0000, 1'b1, OP_LOAD};
        ui_in  = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold.acc", uo_out, 8'h00);
        chk("rst_hold.flags", uio_out, 8'h10);
        @(negedge clk);
        rst_n  = 1'b1;
        uio_in = {4'b0000, 1'b0, OP_LOAD};
        sb.push_back(16'h0010);
        @(posedge clk);
        #1;
        pop_chk("rst_release");

        foreach (tbl[i]) apply(tbl[i]);

        // Reset mid-run must clear state with no clock edge in between.
        apply('{"pre_rst", 1, 1, OP_LOAD, 8'hC3, 8'hC3, 8'h40});
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid.acc", uo_out, 8'h00);
        chk("rst_mid.flags", uio_out, 8'h10);
        @(negedge clk);
        rst_n  = 1'b1;
        ena    = 1'b1;
        uio_in = {4'b0000, 1'b1, OP_LOAD};
        ui_in  = 8'h33;
        sb.push_back(16'h3300);
        @(posedge clk);
        #1;
        pop_chk("first_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
